wb_buffer: RTL

Writeback result buffer sitting directly downstream of the execute-stage adder unit. It captures the registered ALU result and destination register each cycle, queues it in a small FIFO, and drains one entry per cycle into the register-file write port, absorbing cycles where that port is busy. It also provides a combinational bypass lookup so decode can read results that are still queued.

---
 rtl/wb_buffer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/wb_buffer.sv
// wb_buffer
// ---------
// Writeback result buffer placed after the execute-stage adder. Each
// accepted result {rd, data} is queued in a small circular FIFO. The FIFO
// drains one entry per cycle into the register-file write port and holds
// entries while that port is busy. Decode can look up results that have not
// been written yet through a combinational bypass port.
//
// Ports
//   clk       in   rising-edge system clock
//   reset     in   asynchronous, active-high reset
//   ex_valid  in   execute stage offers a result this cycle
//   ex_rd     in   destination register of the offered result
//   ex_data   in   offered result value
//   ex_ready  out  buffer has room (count < DEPTH)
//   wb_stall  in   register-file write port busy this cycle
//   wb_en     out  registered register-file write enable
//   wb_addr   out  registered register-file write address
//   wb_data   out  registered register-file write data
//   byp_addr  in   source register queried by decode
//   byp_hit   out  byp_addr matches a pending write
//   byp_data  out  value of the youngest pending write to byp_addr
//   count     out  number of queued entries
module wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ex_valid,
    input  logic [ADDR_W-1:0]          ex_rd,
    input  logic [DATA_W-1:0]          ex_data,
    output logic                       ex_ready,
    input  logic                       wb_stall,
    output logic                       wb_en,
    output logic [ADDR_W-1:0]          wb_addr,
    output logic [DATA_W-1:0]          wb_data,
    input  logic [ADDR_W-1:0]          byp_addr,
    output logic                       byp_hit,
    output logic [DATA_W-1:0]          byp_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
    logic [ADDR_W-1:0] rd_mem_d   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic              accept;
    logic              store;
    logic              pop;
    logic [PTR_W-1:0]  byp_idx;

    // Handshake decode. ex_ready comes from the registered count only, so a
    // pop on the same edge never creates room for the offer in that cycle.
    // Writes to x0 are accepted but never stored.
    always_comb begin
        ex_ready = (count_q < CNT_W'(DEPTH));
        accept   = ex_valid && ex_ready;
        store    = accept && (ex_rd != '0);
        pop      = !wb_stall && (count_q != '0);
    end

    // Next-state for the FIFO storage, pointers, occupancy and writeback
    // register. The pop reads the head as it was before this edge, so an
    // entry stored at an edge cannot leave at that same edge.
    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wb_en_d    = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;

        if (store) begin
            rd_mem_d[wr_ptr_q]   = ex_rd;
            data_mem_d[wr_ptr_q] = ex_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_mem_q[rd_ptr_q];
            wb_data_d = data_mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end

        if (store && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!store && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control and writeback state; reset flushes every queued entry and
    // drops a pending write immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Entry storage carries no reset: only slots below count are ever
    // observed, and reset clears count.
    always_ff @(posedge clk) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

    // Bypass lookup. Candidates are scanned from lowest to highest priority
    // (wb register, then FIFO oldest to newest) so that a later match
    // overrides an earlier one and the youngest pending write wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = '0;
        if (byp_addr != '0) begin
            if (wb_en_q && (wb_addr_q == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = wb_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                byp_idx = rd_ptr_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (rd_mem_q[byp_idx] == byp_addr)) begin
                    byp_hit  = 1'b1;
                    byp_data = data_mem_q[byp_idx];
                end
            end
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign count   = count_q;

endmodule
